// File: rtl/seq_multdiv_unit.sv
// seq_multdiv_unit: multi-cycle signed shift-add multiply / restoring divide; MULTDIV_FAST_ZERO_EN skips iterations on zero operands
module seq_multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0] opnd, rem, mag_a, mag_b, quo, res;
  logic [WIDTH:0] sum, shifted, diff;
  logic neg, is_div, start, last, skip, exc, finish;
  assign start = ctrl_MULT | ctrl_DIV;
  assign last = cnt == CNT_W'(WIDTH-1);
  assign finish = state == DONE && !start;
  assign mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign busy = state != IDLE || data_resultRDY;
`ifdef MULTDIV_FAST_ZERO_EN
  assign skip = data_operandA == '0 || data_operandB == '0;
`else
  assign skip = 1'b0;
`endif
  always_comb begin
    state_nx = start ? (skip ? DONE : ctrl_MULT ? MULT : DIV) :
               state == DONE ? IDLE :
               ((state == MULT || state == DIV) && last) ? DONE : state;
  end
  // prod holds {accumulator, multiplier} for MULT and {unused, quotient} for DIV
  always_comb begin
    sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
    shifted = {rem, prod[WIDTH-1]};
    diff = shifted - {1'b0, opnd};
    prod_s = neg ? -prod : prod;
    quo = neg ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
    res = is_div ? (opnd == '0 ? '0 : quo) : prod_s[WIDTH-1:0];
    exc = is_div ? (opnd == '0 || (!neg && prod[WIDTH-1]))
                 : prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}};
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      prod <= '0;
      rem <= '0;
      opnd <= '0;
      neg <= 1'b0;
      is_div <= 1'b0;
      data_result <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      state <= state_nx;
      data_resultRDY <= finish;
      if (finish) begin
        data_result <= res;
        data_exception <= exc;
      end
      if (start) begin
        cnt <= '0;
        rem <= '0;
        neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        is_div <= !ctrl_MULT;
        opnd <= ctrl_MULT ? mag_a : mag_b;
        prod <= skip ? '0 : {{WIDTH{1'b0}}, ctrl_MULT ? mag_b : mag_a};
      end else if (state == MULT) begin
        cnt <= last ? '0 : cnt + 1'b1;
        prod <= {sum, prod[WIDTH-1:1]};
      end else if (state == DIV) begin
        cnt <= last ? '0 : cnt + 1'b1;
        rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        prod[WIDTH-1:0] <= {prod[WIDTH-2:0], !diff[WIDTH]};
      end
    end
  end
endmodule

// File: tb/tb_seq_multdiv_unit.sv
// tb_seq_multdiv_unit: randomized and directed checks of seq_multdiv_unit against an arithmetic reference model
module tb_seq_multdiv_unit;
  logic clock = 0, reset = 0, ctrl_MULT = 0, ctrl_DIV = 0;
  logic [31:0] data_operandA = 0, data_operandB = 0;
  logic [31:0] data_result;
  logic data_exception, data_resultRDY, busy;
  int checks = 0, fails = 0;

  always #5 clock = ~clock;

  seq_multdiv_unit dut (
    .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );

  function automatic void model(input logic m, input logic [31:0] a, b,
                                output logic [31:0] r, output logic e);
    longint p;
    logic [31:0] lo;
    if (m) begin
      p = longint'($signed(a)) * longint'($signed(b));
      lo = p[31:0];
      r = lo;
      e = p != longint'($signed(lo));
    end else if (b == 0) begin
      r = 0; e = 1;
    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      r = 32'h80000000; e = 1;
    end else begin
      r = $signed(a) / $signed(b); e = 0;
    end
  endfunction

  function automatic int exp_lat(input logic [31:0] a, b);
`ifdef MULTDIV_FAST_ZERO_EN
    return (a == 0 || b == 0) ? 1 : 33;
`else
    return 33;
`endif
  endfunction

  function automatic logic [31:0] pick();
    int k = $urandom_range(0, 5);
    return k == 0 ? 32'd0 : k == 1 ? 32'($urandom_range(0, 300)) :
           k == 2 ? 32'(-$urandom_range(1, 300)) : 32'($urandom);
  endfunction

  // starts an op, scrambles operands after the start edge, and waits (bounded) for the strobe
  task automatic do_op(input logic m, d, input logic [31:0] a, b, output int lat,
                       output logic [31:0] r, output logic e, output logic busy_ok,
                       output logic rdy_after);
    @(negedge clock);
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
    @(negedge clock);
    ctrl_MULT = 0; ctrl_DIV = 0; data_operandA = $urandom; data_operandB = $urandom;
    lat = 0; busy_ok = 1;
    while (data_resultRDY !== 1'b1 && lat < 60) begin
      busy_ok = busy_ok & (busy === 1'b1);
      @(negedge clock);
      lat++;
    end
    busy_ok = busy_ok & (busy === 1'b1);
    r = data_result; e = data_exception;
    @(negedge clock);
    rdy_after = data_resultRDY;
  endtask

  task automatic test_reset();
    #1 reset = 1;
    #1;
    checks++; if (data_result !== 0) begin fails++; $display("FAIL reset_result got %h want 0", data_result); end
    checks++; if (data_exception !== 0) begin fails++; $display("FAIL reset_exc got %b want 0", data_exception); end
    checks++; if (data_resultRDY !== 0) begin fails++; $display("FAIL reset_rdy got %b want 0", data_resultRDY); end
    checks++; if (busy !== 0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    repeat (2) @(negedge clock);
    reset = 0;
  endtask

  task automatic test_ops(input string tag, input int n, input logic rnd);
    logic ms [8] = '{1, 0, 0, 1, 0, 1, 0, 1};
    logic [31:0] as [8] = '{7, 32'hFFFFFF9C, 100, 32'h10000, 32'h80000000, 32'h80000000, 7, 0};
    logic [31:0] bs [8] = '{32'hFFFFFFFA, 7, 0, 32'h10000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 12345};
    logic m, e, xe, bok, ra;
    logic [31:0] a, b, r, xr;
    int lat;
    for (int i = 0; i < n; i++) begin
      m = rnd ? 1'($urandom_range(0, 1)) : ms[i];
      a = rnd ? pick() : as[i];
      b = rnd ? pick() : bs[i];
      model(m, a, b, xr, xe);
      do_op(m, !m, a, b, lat, r, e, bok, ra);
      checks++; if (r !== xr) begin fails++; $display("FAIL %s%0d_result m=%b a=%h b=%h got %h want %h", tag, i, m, a, b, r, xr); end
      checks++; if (e !== xe) begin fails++; $display("FAIL %s%0d_exc m=%b a=%h b=%h got %b want %b", tag, i, m, a, b, e, xe); end
      checks++; if (lat != exp_lat(a, b)) begin fails++; $display("FAIL %s%0d_latency got %0d want %0d", tag, i, lat, exp_lat(a, b)); end
      checks++; if (bok !== 1) begin fails++; $display("FAIL %s%0d_busy got low want high throughout", tag, i); end
      checks++; if (ra !== 0) begin fails++; $display("FAIL %s%0d_strobe_width got rdy=%b after strobe want 0", tag, i, ra); end
    end
  endtask

  task automatic test_restart();
    logic seen = 0, e, bok, ra;
    logic [31:0] r;
    int lat;
    @(negedge clock);
    ctrl_MULT = 1; data_operandA = 3; data_operandB = 4;
    @(negedge clock);
    ctrl_MULT = 0;
    repeat (9) begin @(negedge clock); seen |= data_resultRDY; end
    do_op(0, 1, 50, 5, lat, r, e, bok, ra);
    checks++; if (seen !== 0) begin fails++; $display("FAIL restart_no_strobe got rdy=%b want 0", seen); end
    checks++; if (r !== 10) begin fails++; $display("FAIL restart_result got %h want %h", r, 32'd10); end
    checks++; if (lat != 33) begin fails++; $display("FAIL restart_latency got %0d want 33", lat); end
    checks++; if (ra !== 0) begin fails++; $display("FAIL restart_single got rdy=%b want 0", ra); end
  endtask

  task automatic test_priority();
    logic e, bok, ra;
    logic [31:0] r;
    int lat;
    do_op(1, 1, 6, 3, lat, r, e, bok, ra);
    checks++; if (r !== 18) begin fails++; $display("FAIL priority_result got %h want %h", r, 32'd18); end
    checks++; if (e !== 0) begin fails++; $display("FAIL priority_exc got %b want 0", e); end
  endtask

  task automatic test_reset_mid();
    logic seen = 0, e, bok, ra;
    logic [31:0] r;
    int lat;
    @(negedge clock);
    ctrl_MULT = 1; data_operandA = 5; data_operandB = 9;
    @(negedge clock);
    ctrl_MULT = 0;
    repeat (14) @(negedge clock);
    #2 reset = 1;
    #1;
    checks++; if (data_result !== 0) begin fails++; $display("FAIL midreset_result got %h want 0", data_result); end
    checks++; if (busy !== 0) begin fails++; $display("FAIL midreset_busy got %b want 0", busy); end
    checks++; if (data_resultRDY !== 0 || data_exception !== 0) begin fails++; $display("FAIL midreset_flags got rdy=%b exc=%b want 0", data_resultRDY, data_exception); end
    @(negedge clock);
    reset = 0;
    repeat (40) begin @(negedge clock); seen |= data_resultRDY; end
    checks++; if (seen !== 0) begin fails++; $display("FAIL midreset_no_strobe got rdy=%b want 0", seen); end
    do_op(1, 0, 2, 2, lat, r, e, bok, ra);
    checks++; if (r !== 4) begin fails++; $display("FAIL after_reset_result got %h want %h", r, 32'd4); end
    checks++; if (lat != 33) begin fails++; $display("FAIL after_reset_latency got %0d want 33", lat); end
  endtask

  initial begin
    test_reset();
    test_ops("directed", 8, 0);
    test_ops("random", 20, 1);
    test_restart();
    test_priority();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/seq_multdiv_unit.md
Name: seq_multdiv_unit

Overview:
- Multi-cycle signed multiply/divide responder for the pipelined processor.
- Serves the processor's ctrl_MULT/ctrl_DIV start pulses and returns data_result with data_exception, qualified by a one-cycle data_resultRDY.
- The processor's execute stage is the initiator and latches the operands; this block is the unit it waits on.
- Multiply is radix-2 shift-add on magnitudes; divide is restoring division on magnitudes; the sign is fixed up at completion.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  master clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- ctrl_MULT  input  1  start-multiply pulse, sampled on the rising edge.
- ctrl_DIV  input  1  start-divide pulse, sampled on the rising edge.
- data_operandA  input  WIDTH  multiplicand/dividend, captured on the start edge.
- data_operandB  input  WIDTH  multiplier/divisor, captured on the start edge.
- data_result  output  WIDTH  signed product (low WIDTH bits) or signed quotient.
- data_exception  output  1  overflow or divide-by-zero; valid while data_resultRDY=1.
- data_resultRDY  output  1  one-cycle completion strobe.
- busy  output  1  high while an operation is in flight.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0.
- States: IDLE, MULT, DIV, DONE.
- Start: on a rising edge with ctrl_MULT=1 or ctrl_DIV=1, from any state:
  - capture |A| and |B| and both sign bits;
  - clear the accumulator/remainder and set counter=0;
  - go to MULT or DIV.
- Simultaneous ctrl_MULT and ctrl_DIV: MULT wins.
- Start while busy or in DONE: the current operation is aborted without a strobe, and the new operation begins.
- MULT: one shift-add step per cycle over a 2*WIDTH-bit product register.
- DIV: one restoring subtract/shift step per cycle over a WIDTH+1-bit remainder.
- Iteration end: after WIDTH iterations (counter reaches WIDTH-1 and wraps), go to DONE.
- DONE lasts exactly one cycle:
  - data_resultRDY=1 and data_exception is valid;
  - next state is IDLE, or MULT/DIV if a start is sampled.
- Latency: start sampled at edge E0 -> data_resultRDY high in the cycle after edge E(WIDTH+1), i.e. 33 cycles for WIDTH=32.
- busy: 1 from E0 through the DONE cycle inclusive.
- data_result holds its value after DONE until the next completion or reset; it is not cleared at start.
- Sign rule: result is negated when sign(A) xor sign(B) = 1.
- Division truncates toward zero; the remainder is discarded.
- Multiply exception: the signed 2*WIDTH-bit product is not the sign-extension of its low WIDTH bits. data_result = low WIDTH bits anyway.
- Divide by zero (B=0): data_exception=1, data_result=0. Full latency still applies.
- Most-negative / -1 (0x80000000 / 0xFFFFFFFF): data_exception=1, data_result=0x80000000.
- Operand changes after the start edge have no effect.
- Reset mid-operation: immediate return to IDLE with all outputs 0; no strobe is produced.

Optional Feature:
- Macro: MULTDIV_FAST_ZERO_EN.
- Defined: a start with a multiply operand equal to 0, a zero dividend, or a zero divisor skips the iterations.
  - Next state is DONE directly, so data_resultRDY is high in the cycle after E1 (latency 1).
  - Result and exception are the same as the full-latency values: 0 with exception=0, except divisor=0 which gives exception=1.
- Undefined: every operation takes WIDTH+1 cycles regardless of operand values.

Test Plan:
- MULT 7 x -6: RDY exactly one cycle, 33 cycles after start; result=0xFFFFFFD6 (-42), exception=0; busy high for the whole interval.
- DIV -100 / 7: result=0xFFFFFFF2 (-14), exception=0. Then DIV 100 / 0: result=0, exception=1 at 33 cycles (1 cycle with MULTDIV_FAST_ZERO_EN).
- MULT 0x00010000 x 0x00010000: result=0x00000000, exception=1. MULT 0x80000000 / 0xFFFFFFFF as DIV: result=0x80000000, exception=1.
- Restart and priority:
  - start MULT 3x4, then at cycle 10 start DIV 50/5: no strobe for the MULT; a single RDY 33 cycles after the DIV start with result=10;
  - asserting ctrl_MULT and ctrl_DIV together with A=6, B=3 yields 18.
- Reset and operand stability:
  - assert reset asynchronously at cycle 15 of a MULT: all outputs 0 immediately, no RDY afterward;
  - a new MULT 2x2 after reset returns 4;
  - changing the operands mid-operation does not alter the result.
